// File: rtl/logic_op_defs.sv
// Shared definitions for the logic-op arbiter: opcode map and FSM state encoding.
package logic_op_defs;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_NOTB = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational bitwise logic-op datapath shared by both requesters.
// Ports:
//   op  - 3-bit opcode
//   a,b - WIDTH-bit operands (a ignored for NOT-b)
//   y   - WIDTH-bit bitwise result (0 for the reserved opcode)
//   err - high when the reserved opcode is presented
module logic_op_unit
    import logic_op_defs::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             err
);

    // Opcode decode; anything outside the defined map flags an error.
    always_comb begin
        y   = '0;
        err = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_NOTB: y = ~b;
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: begin
                y   = '0;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one logic-op unit between two requesters.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   req0/op0/a0/b0      - requester 0 request and operation
//   req1/op1/a1/b1      - requester 1 request and operation
//   gnt0, gnt1          - one-cycle capture pulses (during EXEC)
//   result/res_id/res_err - registered result, owner, reserved-op flag
//   res_valid           - one-cycle result qualifier (during DONE)
//   busy                - high whenever not IDLE
module logic_op_arbiter
    import logic_op_defs::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [2:0]       op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt1,
    output logic [WIDTH-1:0] result,
    output logic             res_valid,
    output logic             res_id,
    output logic             res_err,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             last_id_q, last_id_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             res_valid_q, res_valid_d;
    logic             res_id_q, res_id_d;
    logic             res_err_q, res_err_d;
    logic             busy_q, busy_d;
    logic             winner_c;
    logic [WIDTH-1:0] y_c;
    logic             err_c;

    logic_op_unit #(.WIDTH(WIDTH)) u_unit (
        .op  (op_q),
        .a   (a_q),
        .b   (b_q),
        .y   (y_c),
        .err (err_c)
    );

    // On a tie the requester that did not win last time is chosen.
    assign winner_c = (req0 && req1) ? ~last_id_q : req1;

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        last_id_d   = last_id_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        result_d    = result_q;
        res_valid_d = 1'b0;
        res_id_d    = res_id_q;
        res_err_d   = res_err_q;
        busy_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d   = ST_EXEC;
                    last_id_d = winner_c;
                    busy_d    = 1'b1;
                    if (winner_c) begin
                        op_d   = op1;
                        a_d    = a1;
                        b_d    = b1;
                        gnt1_d = 1'b1;
                    end else begin
                        op_d   = op0;
                        a_d    = a0;
                        b_d    = b0;
                        gnt0_d = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                state_d     = ST_DONE;
                result_d    = y_c;
                res_err_d   = err_c;
                res_id_d    = last_id_q;
                res_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= 3'b000;
            a_q         <= '0;
            b_q         <= '0;
            last_id_q   <= 1'b1;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            result_q    <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            last_id_q   <= last_id_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            result_q    <= result_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_err_q   <= res_err_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign result    = result_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_err   = res_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed self-checking bench for logic_op_arbiter (WIDTH=8).
module tb_logic_op_arbiter;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             req0, req1;
    logic [2:0]       op0, op1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic             gnt0, gnt1;
    logic [WIDTH-1:0] result;
    logic             res_valid, res_id, res_err, busy;

    int unsigned pass_cnt;
    int unsigned total_cnt;

    logic_op_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .op0       (op0),
        .a0        (a0),
        .b0        (b0),
        .gnt0      (gnt0),
        .req1      (req1),
        .op1       (op1),
        .a1        (a1),
        .b1        (b1),
        .gnt1      (gnt1),
        .result    (result),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_err   (res_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] outs;
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
        op0 = 3'b000; a0 = 8'hFF; b0 = 8'h0F;
        op1 = 3'b001; a1 = 8'h00; b1 = 8'h00;
        repeat (3) tick();
        outs = {gnt0, gnt1, res_valid, res_err, res_id, busy, result[5:0]};
        total_cnt++;
        if ({outs, result[7:6]} !== 14'd0)
            $display("FAIL reset_outputs: got %b want 0", {outs, result[7:6]});
        else pass_cnt++;
        rst = 1'b0;
        tick();
        total_cnt++;
        if ({gnt0, gnt1, busy} !== 3'b101)
            $display("FAIL reset_first_grant: got gnt0/gnt1/busy=%b want 101", {gnt0, gnt1, busy});
        else pass_cnt++;
        req0 = 1'b0;
        tick();
        total_cnt++;
        if ({res_valid, res_id, res_err, result} !== {3'b100, 8'h0F})
            $display("FAIL reset_first_result: got v/id/err=%b res=%h want 100 0f",
                     {res_valid, res_id, res_err}, result);
        else pass_cnt++;
        req1 = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_single();
        req0 = 1'b1; op0 = 3'b101; a0 = 8'hF0; b0 = 8'h3C;
        tick();
        total_cnt++;
        if ({gnt0, gnt1, res_valid} !== 3'b100)
            $display("FAIL single_grant: got gnt0/gnt1/valid=%b want 100", {gnt0, gnt1, res_valid});
        else pass_cnt++;
        req0 = 1'b0;
        tick();
        total_cnt++;
        if ({res_valid, res_id, res_err, gnt0, result} !== {4'b1000, 8'hCC})
            $display("FAIL single_result: got v/id/err/gnt0=%b res=%h want 1000 cc",
                     {res_valid, res_id, res_err, gnt0}, result);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({res_valid, busy, result} !== {2'b00, 8'hCC})
            $display("FAIL single_hold: got v/busy=%b res=%h want 00 cc", {res_valid, busy}, result);
        else pass_cnt++;
    endtask

    task automatic test_notb_rsvd();
        req1 = 1'b1; op1 = 3'b100; a1 = 8'hAA; b1 = 8'h0F;
        tick();
        total_cnt++;
        if ({gnt0, gnt1} !== 2'b01)
            $display("FAIL notb_grant: got gnt0/gnt1=%b want 01", {gnt0, gnt1});
        else pass_cnt++;
        req1 = 1'b0;
        tick();
        total_cnt++;
        if ({res_valid, res_id, res_err, result} !== {3'b110, 8'hF0})
            $display("FAIL notb_result: got v/id/err=%b res=%h want 110 f0",
                     {res_valid, res_id, res_err}, result);
        else pass_cnt++;
        tick();
        req1 = 1'b1; op1 = 3'b111; a1 = 8'hFF; b1 = 8'hFF;
        tick();
        req1 = 1'b0;
        tick();
        total_cnt++;
        if ({res_valid, res_id, res_err, result} !== {3'b111, 8'h00})
            $display("FAIL rsvd_result: got v/id/err=%b res=%h want 111 00",
                     {res_valid, res_id, res_err}, result);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({res_valid, res_err} !== 2'b01)
            $display("FAIL rsvd_hold: got v/err=%b want 01", {res_valid, res_err});
        else pass_cnt++;
    endtask

    task automatic test_late();
        req0 = 1'b1; op0 = 3'b010; a0 = 8'hF0; b0 = 8'h3C;
        tick();
        total_cnt++;
        if (gnt0 !== 1'b1)
            $display("FAIL late_gnt0: got %b want 1", gnt0);
        else pass_cnt++;
        req0 = 1'b0;
        req1 = 1'b1; op1 = 3'b110; a1 = 8'hF0; b1 = 8'h3C;
        tick();
        total_cnt++;
        if ({gnt1, res_valid, res_id, result} !== {3'b010, 8'hCF})
            $display("FAIL late_first_done: got gnt1/v/id=%b res=%h want 010 cf",
                     {gnt1, res_valid, res_id}, result);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({gnt1, busy} !== 2'b00)
            $display("FAIL late_idle: got gnt1/busy=%b want 00", {gnt1, busy});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({gnt0, gnt1} !== 2'b01)
            $display("FAIL late_gnt1_timing: got gnt0/gnt1=%b want 01", {gnt0, gnt1});
        else pass_cnt++;
        req1 = 1'b0;
        tick();
        total_cnt++;
        if ({res_valid, res_id, res_err, result} !== {3'b110, 8'h33})
            $display("FAIL late_second_result: got v/id/err=%b res=%h want 110 33",
                     {res_valid, res_id, res_err}, result);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_contention();
        logic [WIDTH-1:0] exp_res;
        int               grants;
        int               budget;
        bit               exp_id;
        req0 = 1'b1; op0 = 3'b001; a0 = 8'h12; b0 = 8'h40;
        req1 = 1'b1; op1 = 3'b011; a1 = 8'h0F; b1 = 8'h30;
        grants = 0;
        budget = 40;
        while (grants < 4 && budget > 0) begin
            tick();
            budget--;
            if (gnt0 && gnt1) begin
                total_cnt++;
                $display("FAIL contention_double_grant: got gnt0/gnt1=11 want at most one");
            end
            if (gnt0 || gnt1) begin
                exp_id  = (grants % 2) == 1;
                exp_res = exp_id ? 8'hC0 : 8'h52;
                total_cnt++;
                if (gnt1 !== exp_id)
                    $display("FAIL contention_order: grant %0d got gnt1=%b want %b", grants, gnt1, exp_id);
                else pass_cnt++;
                if (gnt1) req1 = 1'b0; else req0 = 1'b0;
                tick();
                budget--;
                total_cnt++;
                if ({res_valid, res_id, result} !== {1'b1, exp_id, exp_res})
                    $display("FAIL contention_result: grant %0d got v/id=%b res=%h want 1%b %h",
                             grants, {res_valid, res_id}, result, exp_id, exp_res);
                else pass_cnt++;
                req0 = 1'b1; req1 = 1'b1;
                grants++;
            end
        end
        if (grants < 4) begin
            total_cnt++;
            $display("FAIL contention_timeout: got %0d grants want 4", grants);
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        bit bad;
        req0 = 1'b1; op0 = 3'b000; a0 = 8'hFF; b0 = 8'hFF;
        tick();
        total_cnt++;
        if ({gnt0, busy} !== 2'b11)
            $display("FAIL midrst_grant: got gnt0/busy=%b want 11", {gnt0, busy});
        else pass_cnt++;
        req0 = 1'b0;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({gnt0, busy, res_valid} !== 3'b000)
            $display("FAIL midrst_async: got gnt0/busy/v=%b want 000", {gnt0, busy, res_valid});
        else pass_cnt++;
        tick();
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (res_valid || busy || gnt0 || gnt1) bad = 1'b1;
        end
        total_cnt++;
        if (bad !== 1'b0)
            $display("FAIL midrst_quiet: got activity after reset want none");
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst  = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        op0 = 3'b000; a0 = '0; b0 = '0;
        op1 = 3'b000; a1 = '0; b1 = '0;
        test_reset();
        test_single();
        test_notb_rsvd();
        test_late();
        test_contention();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/logic_op_arbiter.md
Name: logic_op_arbiter

Overview:
- Shares a single WIDTH-bit bitwise logic-op unit between two requesters. The unit implements AND, OR, NAND, NOR, NOT-b, XOR and XNOR.
- A round-robin arbiter picks one request and latches its opcode and operands. The block then computes the result, registers it, and returns it tagged with the requester ID.
- Sits between two client blocks and the shared combinational logic-op datapath. Only one operation is in flight at a time.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 1..32).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req0  input  1  requester 0 operation request (level; hold until gnt0)
op0  input  3  requester 0 opcode
a0  input  WIDTH  requester 0 operand a
b0  input  WIDTH  requester 0 operand b
gnt0  output  1  one-cycle pulse: requester 0 inputs captured
req1  input  1  requester 1 operation request
op1  input  3  requester 1 opcode
a1  input  WIDTH  requester 1 operand a
b1  input  WIDTH  requester 1 operand b
gnt1  output  1  one-cycle pulse: requester 1 inputs captured
result  output  WIDTH  registered operation result
res_valid  output  1  one-cycle pulse: result/res_id/res_err valid
res_id  output  1  requester that owns the result (0 or 1)
res_err  output  1  reserved opcode was used; result forced to 0
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset is asynchronous and active-high. While rst=1:
  - state=IDLE.
  - gnt0, gnt1, res_valid, res_err, res_id, busy and result are all 0.
  - Round-robin pointer last_id=1, so requester 0 wins the first tie.
  - Captured operand/opcode registers are 0.
- Opcode map:
  - 000 AND, 001 OR, 010 NAND, 011 NOR
  - 100 NOT b (a ignored), 101 XOR, 110 XNOR
  - 111 reserved: result=0, res_err=1
- All ops are bitwise across WIDTH. There is no carry and no width growth.
- FSM: IDLE -> EXEC -> DONE -> IDLE.
  - IDLE: busy=0. If req0 or req1 is sampled high at a clock edge:
    - Choose the winner. If only one request is high, it wins. If both are high, the winner is the requester != last_id.
    - Latch op/a/b of the winner, set last_id=winner.
    - Assert gnt_winner for exactly the next cycle and go to EXEC.
    - If neither request is high, stay in IDLE.
  - EXEC (1 cycle): busy=1; the gnt pulse is visible in this cycle. At the end of the cycle, register result=f(op,a,b) and res_err, set res_id=winner, and go to DONE.
  - DONE (1 cycle): busy=1, res_valid=1, and result/res_id/res_err are stable. Requests are not sampled in DONE. Next state is IDLE.
- Outputs result, res_id and res_err hold their value after DONE until the next EXEC overwrites them. res_valid is the only qualifier.
- Latency and throughput:
  - Request sampled at edge k -> gnt during cycle k+1 -> res_valid during cycle k+2.
  - Maximum rate is one operation per 3 cycles: IDLE, EXEC, DONE.
- Requester rules:
  - Hold req and its inputs stable until gnt is seen. Inputs are ignored after capture.
  - req still high in the next IDLE cycle counts as a new request. Clients drop req in the cycle gnt is high.
  - req dropped before grant is simply withdrawn; no error.
- Fairness: with both requesters continuously requesting, grants alternate 0,1,0,1. Neither requester waits more than one other operation.
- Simultaneous events: a request arriving during EXEC/DONE waits; it is sampled in the next IDLE.
- Reset mid-operation: the in-flight operation is discarded. No res_valid is produced, and no gnt is emitted after rst deasserts until a fresh request in IDLE.
- gnt0 and gnt1 are never high together. res_valid is never high in IDLE or EXEC.

Decomposition:
- Shared include/package file logic_op_defs: opcode localparams (OP_AND..OP_XNOR, OP_RSVD=3'b111), state encodings (ST_IDLE, ST_EXEC, ST_DONE, 2-bit).
- Sub-module logic_op_unit: purely combinational, parameter WIDTH; inputs op, a, b; outputs y, err. Instantiated once. The arbiter holds all sequential state.

Test Plan:
- Reset: hold rst=1 with req0=req1=1 for 3 cycles -> all outputs 0, busy=0; release -> gnt0 next cycle (last_id=1 after reset).
- Single op: WIDTH=8, req0=1, op0=101, a0=8'hF0, b0=8'h3C -> gnt0 in cycle k+1, res_valid in k+2 with result=8'hCC, res_id=0, res_err=0.
- Contention: req0=req1=1 held continuously, each dropped for one cycle on its own gnt and then re-raised -> grant order 0,1,0,1; results tagged with matching res_id; never two gnts in one cycle.
- NOT-b and reserved: req1 op1=100, a1=8'hAA, b1=8'h0F -> result=8'hF0. Then op1=111 -> result=8'h00, res_err=1.
- Late arrival: req1 rises during EXEC of a req0 op -> req1 is not granted until the IDLE cycle after DONE; gnt1 occurs exactly 3 cycles after gnt0.
- Reset mid-op: assert rst during EXEC -> no res_valid appears; after release with no requests, busy stays 0 and no gnt is emitted.
